y_frame_ctrl: RTL and testbench

Y_FRAME_CTRL -- requirements
Module: y_frame_ctrl

---
 rtl/y_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_y_frame_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/y_frame_ctrl.sv
// Frame capture controller ahead of the rgb2y datapath: gates whole frames,
// registers the stream one cycle and checks line length and line count.
module y_frame_ctrl #(
    parameter int HBITS = 12,
    parameter int VBITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [HBITS-1:0] h_active_i,
    input  logic [VBITS-1:0] v_active_i,
    input  logic [23:0]      rgb_i,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    output logic [23:0]      rgb_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             frame_start_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             line_err_o,
    output logic             frame_err_o,
    output logic [VBITS-1:0] line_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t state_q, state_d;

    logic             vs_q, dv_q;
    logic [23:0]      rgb_q, rgb_d;
    logic             dvo_q, dvo_d;
    logic             hso_q, vso_q;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             lerr_q, lerr_d;
    logic             ferr_q, ferr_d;
    logic [HBITS-1:0] pix_q, pix_d;
    logic [VBITS-1:0] line_q, line_d;
    logic [HBITS-1:0] hsh_q, hsh_d;
    logic [VBITS-1:0] vsh_q, vsh_d;

    logic             vs_fall, vs_rise, dv_fall;
    logic             gate;
    logic             line_end;
    logic [VBITS-1:0] lines_next;

    assign vs_fall = vs_q & ~vs_i;
    assign vs_rise = ~vs_q & vs_i;
    assign dv_fall = dv_q & ~dv_i;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        lerr_d     = 1'b0;
        ferr_d     = ferr_q;
        pix_d      = pix_q;
        line_d     = line_q;
        hsh_d      = hsh_q;
        vsh_d      = vsh_q;
        lines_next = line_q;
        line_end   = 1'b0;

        // The vs_fall cycle already belongs to the frame so pixel 0 survives.
        gate  = (state_q == ACTIVE) || (state_q == WAIT_VS && vs_fall);
        rgb_d = gate ? rgb_i : 24'h0;
        dvo_d = gate & dv_i;

        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d = ACTIVE;
                    hsh_d   = h_active_i;
                    vsh_d   = v_active_i;
                    pix_d   = {{(HBITS-1){1'b0}}, dv_i};
                    line_d  = '0;
                    ferr_d  = 1'b0;
                    start_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (dv_i && pix_q != '1) pix_d = pix_q + HBITS'(1);
                // A line still valid when vsync rises is a truncated line.
                line_end = dv_fall || (vs_rise && dv_i);
                if (line_end) begin
                    pix_d = '0;
                    if (line_q != '1) lines_next = line_q + VBITS'(1);
                    line_d = lines_next;
                    if (dv_i || pix_q != hsh_q) begin
                        lerr_d = 1'b1;
                        ferr_d = 1'b1;
                    end
                end
                if (vs_rise) begin
                    done_d  = 1'b1;
                    pix_d   = '0;
                    state_d = en_i ? WAIT_VS : IDLE;
                    if (lines_next != vsh_q) ferr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            dv_q    <= 1'b0;
            rgb_q   <= '0;
            dvo_q   <= 1'b0;
            hso_q   <= 1'b0;
            vso_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            hsh_q   <= '0;
            vsh_q   <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_i;
            dv_q    <= dv_i;
            rgb_q   <= rgb_d;
            dvo_q   <= dvo_d;
            hso_q   <= hs_i;
            vso_q   <= vs_i;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            lerr_q  <= lerr_d;
            ferr_q  <= ferr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            hsh_q   <= hsh_d;
            vsh_q   <= vsh_d;
        end
    end

    assign rgb_o         = rgb_q;
    assign dv_o          = dvo_q;
    assign hs_o          = hso_q;
    assign vs_o          = vso_q;
    assign frame_start_o = start_q;
    assign frame_done_o  = done_q;
    assign busy_o        = busy_q;
    assign line_err_o    = lerr_q;
    assign frame_err_o   = ferr_q;
    assign line_cnt_o    = line_q;

endmodule

// File: tb/tb_y_frame_ctrl.sv
// Bench for y_frame_ctrl: directed frame scenarios plus random frames,
// expectations derived per frame from line lengths and enable history.
module tb_y_frame_ctrl;

    localparam int HB = 12;
    localparam int VB = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic [HB-1:0] h_active_i = '0;
    logic [VB-1:0] v_active_i = '0;
    logic [23:0]   rgb_i = '0;
    logic          dv_i = 1'b0;
    logic          hs_i = 1'b0;
    logic          vs_i = 1'b0;
    logic [23:0]   rgb_o;
    logic          dv_o, hs_o, vs_o;
    logic          frame_start_o, frame_done_o, busy_o;
    logic          line_err_o, frame_err_o;
    logic [VB-1:0] line_cnt_o;

    y_frame_ctrl #(.HBITS(HB), .VBITS(VB)) dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .h_active_i(h_active_i), .v_active_i(v_active_i),
        .rgb_i(rgb_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
        .busy_o(busy_o), .line_err_o(line_err_o),
        .frame_err_o(frame_err_o), .line_cnt_o(line_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference state
    bit cur_cap = 1'b0;
    int exp_lines = 0;
    bit exp_ferr = 1'b0;
    int h_cur = 0;
    int v_cur = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit vs, input bit hs, input bit dv,
                       input bit cap, input bit st, input bit dn,
                       input bit le);
        logic [23:0] px;
        px = 24'($urandom);
        vs_i = vs; hs_i = hs; dv_i = dv; rgb_i = px;
        @(posedge clk);
        @(negedge clk);
        chk("dv_o", 32'(dv_o), 32'(cap & dv));
        chk("rgb_o", 32'(rgb_o), 32'(cap ? px : 24'h0));
        chk("hs_o", 32'(hs_o), 32'(hs));
        chk("vs_o", 32'(vs_o), 32'(vs));
        chk("frame_start", 32'(frame_start_o), 32'(st));
        chk("frame_done", 32'(frame_done_o), 32'(dn));
        chk("line_err", 32'(line_err_o), 32'(le));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"}, 32'(rgb_o), 0);
        chk({tag, "_dv"}, 32'(dv_o), 0);
        chk({tag, "_hs"}, 32'(hs_o), 0);
        chk({tag, "_vs"}, 32'(vs_o), 0);
        chk({tag, "_start"}, 32'(frame_start_o), 0);
        chk({tag, "_done"}, 32'(frame_done_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_lerr"}, 32'(line_err_o), 0);
        chk({tag, "_ferr"}, 32'(frame_err_o), 0);
        chk({tag, "_lcnt"}, 32'(line_cnt_o), 0);
    endtask

    // Three-cycle vsync pulse; the first cycle closes any captured frame.
    task automatic vs_pulse(input bit dv_first);
        bit was;
        was = cur_cap;
        if (was && dv_first) begin
            exp_lines++;
            exp_ferr = 1'b1;
        end
        if (was && exp_lines != v_cur) exp_ferr = 1'b1;
        cyc(1, 0, dv_first, was, 0, was, was && dv_first);
        cur_cap = 1'b0;
        if (was) begin
            chk("line_cnt", 32'(line_cnt_o), 32'(exp_lines));
            chk("frame_err", 32'(frame_err_o), 32'(exp_ferr));
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("busy_idle_wait", 32'(busy_o), 32'(en_i));
        if (was) chk("line_cnt_hold", 32'(line_cnt_o), 32'(exp_lines));
    endtask

    task automatic body(input int lens[$], input int trunc,
                        input int h, input int v,
                        input int rst_line, input int en_line,
                        input bit en_val);
        bit bad;
        h_active_i = HB'(h);
        v_active_i = VB'(v);
        cur_cap = en_i;
        if (cur_cap) begin
            h_cur = h; v_cur = v;
            exp_lines = 0; exp_ferr = 1'b0;
        end
        cyc(0, 0, 0, cur_cap, cur_cap, 0, 0);
        if (cur_cap) begin
            chk("frame_err_clr", 32'(frame_err_o), 0);
            chk("busy_active", 32'(busy_o), 1);
        end
        // Shadowed limits must ignore later changes.
        h_active_i = HB'($urandom);
        v_active_i = VB'($urandom);
        cyc(0, 0, 0, cur_cap, 0, 0, 0);
        foreach (lens[i]) begin
            for (int p = 0; p < lens[i]; p++) begin
                if (i == en_line && p == 0) en_i = en_val;
                if (i == rst_line && p == 1) begin
                    rst = 1'b1; vs_i = 0; hs_i = 0; dv_i = 1;
                    rgb_i = 24'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    chk_zero("midrst");
                    cur_cap = 1'b0;
                end else begin
                    cyc(0, 0, 1, cur_cap, 0, 0, 0);
                end
            end
            bad = (lens[i] != h_cur);
            if (cur_cap) begin
                exp_lines++;
                if (bad) exp_ferr = 1'b1;
            end
            cyc(0, 1, 0, cur_cap, 0, 0, cur_cap && bad);
            cyc(0, 0, 0, cur_cap, 0, 0, 0);
        end
        for (int p = 0; p < trunc; p++) cyc(0, 0, 1, cur_cap, 0, 0, 0);
        vs_pulse(trunc != 0);
    endtask

    initial begin
        int q[$];
        int h, v, nl, tr, el;
        bit ev;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        en_i = 1'b1;
        vs_pulse(0);

        body('{4, 4, 4}, 0, 4, 3, -1, -1, 1'b0);
        body('{4, 5, 4}, 0, 4, 3, -1, -1, 1'b0);
        body('{4, 4}, 2, 4, 3, -1, -1, 1'b0);
        body('{4, 4, 4}, 0, 4, 3, -1, 1, 1'b0);
        body('{4, 4, 4}, 0, 4, 3, -1, 1, 1'b1);
        body('{4, 4, 4}, 0, 4, 3, -1, -1, 1'b0);
        body('{4, 4, 4}, 0, 4, 3, 1, -1, 1'b0);
        body('{4, 4, 4}, 0, 4, 3, -1, -1, 1'b0);
        body('{3, 3}, 0, 0, 2, -1, -1, 1'b0);
        body('{3, 3, 3}, 0, 3, 2, -1, -1, 1'b0);

        for (int f = 0; f < 12; f++) begin
            h = $urandom_range(2, 6);
            v = $urandom_range(2, 4);
            nl = v + (($urandom % 3) == 0 ? 1 : 0);
            q.delete();
            for (int i = 0; i < nl; i++)
                q.push_back(h + (($urandom % 4) == 0 ? 1 : 0));
            tr = (($urandom % 4) == 0) ? $urandom_range(1, 3) : 0;
            el = (($urandom % 3) == 0) ? $urandom_range(0, nl - 1) : -1;
            ev = ($urandom % 4) != 0;
            body(q, tr, h, v, -1, el, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
